// File: rtl/mem_data_memory_sync_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the synchronous MEM-stage data memory:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 is illegal)
//   - LATENCY_MAX, the deepest response pipeline the memory supports
//   - controller state enum
//   - pipeline stage record
//   - helpers for alignment fault detection and big-endian lane extract
// No ports (package).
// ----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int LATENCY_MAX = 4;

    // ST_RST is the value held while rst_n is low; it lasts one edge after release.
    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    typedef struct packed {
        logic        valid;
        logic        load;
        logic        fault;
        logic        uns;
        logic [1:0]  size;
        logic [1:0]  off;
        logic [31:0] word;
    } stage_t;

    function automatic logic access_fault(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: access_fault = 1'b0;
            SZ_HALF: access_fault = off[0];
            SZ_WORD: access_fault = (off != 2'b00);
            default: access_fault = 1'b1;
        endcase
    endfunction

    // Big-endian: byte offset 0 is word[31:24]; ~off equals 3-off for a 2-bit offset.
    function automatic logic [31:0] be_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {~off, 3'b000});
        h = 16'(word >> {~off[1], 4'b0000});
        case (size)
            SZ_BYTE: be_extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: be_extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: be_extract = word;
        endcase
    endfunction

endpackage

// File: rtl/mem_data_memory_sync_if.sv
// ----------------------------------------------------------------------------
// mem_data_memory_sync_if
// Request/response bus of the synchronous data memory.
//   req_valid/req_ready   handshake, accept on rising edge when both high
//   req_write             1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned          loads: 1 = zero-extend, 0 = sign-extend
//   req_addr              byte address
//   req_wdata             right-aligned store data
//   rsp_valid             response strobe, no backpressure
//   rsp_rdata             extended load data, 0 for stores/faults/idle
//   rsp_fault             misaligned or illegal-size access
// Modports: master (pipeline side), slave (memory side).
// ----------------------------------------------------------------------------
interface mem_data_memory_sync_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/mem_data_memory_sync_load_align.sv
// ----------------------------------------------------------------------------
// mem_load_align
// Combinational big-endian lane select and sign/zero extension of a 32-bit
// word. Shared between the data memory response stage and the fetch path.
//   i_word      raw 32-bit memory word
//   i_off       byte offset within the word
//   i_size      access size encoding
//   i_unsigned  1 = zero-extend, 0 = sign-extend
//   o_data      extended result
// ----------------------------------------------------------------------------
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);
    assign o_data = be_extract(i_word, i_off, i_size, i_unsigned);
endmodule

// File: rtl/mem_data_memory_sync.sv
// ----------------------------------------------------------------------------
// mem_data_memory_sync
// Synchronous byte-addressed big-endian data memory with a fixed response
// latency of LATENCY cycles (1..LATENCY_MAX), fully pipelined.
//   i_clk    clock, all state on rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      mem_data_memory_sync_if.slave request/response port
// Parameters: ADDR_WIDTH (decoded byte-address bits), LATENCY.
// Optional macro MEM_ZERO_INIT_EN: zero-fill sweep of the array after reset,
// one word per cycle, with req_ready held low until it completes.
// ----------------------------------------------------------------------------
module mem_data_memory_sync
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    mem_data_memory_sync_if.slave bus
);
    localparam int IW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** IW;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_ready;
`ifdef MEM_ZERO_INIT_EN
    logic          w_init_we;
    logic [IW-1:0] r_init_cnt;
`endif

    logic          w_accept;
    logic          w_fault;
    logic          w_store_we;
    logic [IW-1:0] w_idx;
    logic [1:0]    w_off;
    logic [3:0]    w_be;
    logic [31:0]   w_wlanes;
    logic [31:0]   r_mem [DEPTH];
    stage_t        w_stage0;
    stage_t        r_pipe [LATENCY];
    stage_t        w_last;
    logic [31:0]   w_aligned;
    logic          w_unused_addr;

    // ---------------- controller FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_RST;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
`ifdef MEM_ZERO_INIT_EN
            ST_RST:  w_state_nxt = ST_INIT;
            ST_INIT: if (&r_init_cnt) w_state_nxt = ST_RUN;
`else
            ST_RST:  w_state_nxt = ST_RUN;
`endif
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RST;
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
`ifdef MEM_ZERO_INIT_EN
        w_init_we = 1'b0;
`endif
        case (r_state)
`ifdef MEM_ZERO_INIT_EN
            ST_INIT: w_init_we = 1'b1;
`endif
            ST_RUN:  w_ready = 1'b1;
            default: ;
        endcase
    end

`ifdef MEM_ZERO_INIT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       r_init_cnt <= '0;
        else if (w_init_we) r_init_cnt <= r_init_cnt + 1'b1;
    end
`endif

    // ---------------- request decode ----------------
    assign w_accept      = bus.req_valid && w_ready;
    assign w_off         = bus.req_addr[1:0];
    assign w_idx         = bus.req_addr[ADDR_WIDTH-1:2];
    assign w_fault       = access_fault(bus.req_size, w_off);
    assign w_store_we    = w_accept && bus.req_write && !w_fault;
    // upper address bits wrap by design
    assign w_unused_addr = ^bus.req_addr[31:ADDR_WIDTH];

    // w_be bit 3 is the most significant lane, i.e. byte offset 0.
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = bus.req_wdata;
        case (bus.req_size)
            SZ_BYTE: begin
                w_be     = 4'b1000 >> w_off;
                w_wlanes = {4{bus.req_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be     = w_off[1] ? 4'b0011 : 4'b1100;
                w_wlanes = {2{bus.req_wdata[15:0]}};
            end
            SZ_WORD: w_be = 4'b1111;
            default: ;
        endcase
    end

    // ---------------- storage ----------------
    // Write enables come from async-reset state, so nothing commits while rst_n is low.
    always_ff @(posedge i_clk) begin
        if (w_store_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
            end
        end
`ifdef MEM_ZERO_INIT_EN
        if (w_init_we) r_mem[r_init_cnt] <= '0;
`endif
    end

    // ---------------- response pipeline ----------------
    // The array is sampled at the acceptance edge; the store for the previous
    // cycle has already committed, giving write-then-read forwarding for free.
    always_comb begin
        w_stage0 = '0;
        if (w_accept) begin
            w_stage0.valid = 1'b1;
            w_stage0.load  = !bus.req_write;
            w_stage0.fault = w_fault;
            w_stage0.uns   = bus.req_unsigned;
            w_stage0.size  = bus.req_size;
            w_stage0.off   = w_off;
            w_stage0.word  = r_mem[w_idx];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < LATENCY; s++) r_pipe[s] <= '0;
        end else begin
            r_pipe[0] <= w_stage0;
            for (int s = 1; s < LATENCY; s++) r_pipe[s] <= r_pipe[s-1];
        end
    end

    assign w_last = r_pipe[LATENCY-1];

    mem_load_align u_align (
        .i_word     (w_last.word),
        .i_off      (w_last.off),
        .i_size     (w_last.size),
        .i_unsigned (w_last.uns),
        .o_data     (w_aligned)
    );

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = w_last.valid;
    assign bus.rsp_fault = w_last.valid && w_last.fault;
    assign bus.rsp_rdata = (w_last.valid && w_last.load && !w_last.fault) ? w_aligned : '0;

endmodule

// File: tb/tb_mem_data_memory_sync.sv
module tb_mem_data_memory_sync;
    import mem_pkg::*;

    localparam int AW    = 12;
    localparam int LAT   = 3;
    localparam int DEPTH = 2 ** (AW - 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_data_memory_sync_if bus_if();

    mem_data_memory_sync #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_if)
    );

    typedef struct {
        int          gap;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        fault;
        int          due;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   next_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input int gap, input logic wr, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] er,
                                input logic ef);
        vec_t v;
        v.gap = gap; v.wr = wr; v.size = size; v.uns = uns;
        v.addr = addr; v.wdata = wdata; v.exp_rdata = er; v.exp_fault = ef;
        return v;
    endfunction

    // Response monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (bus_if.rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 at cyc %0d, required no response", cyc);
            end else begin
                e = sbq.pop_front();
                tests++;
                if (bus_if.rsp_rdata !== e.rdata) begin
                    fails++;
                    $display("FAIL req%0d_rdata: got %h, required %h", e.id, bus_if.rsp_rdata, e.rdata);
                end
                tests++;
                if (bus_if.rsp_fault !== e.fault) begin
                    fails++;
                    $display("FAIL req%0d_fault: got %b, required %b", e.id, bus_if.rsp_fault, e.fault);
                end
                tests++;
                if (cyc != e.due) begin
                    fails++;
                    $display("FAIL req%0d_latency: got rsp at cyc %0d, required cyc %0d", e.id, cyc, e.due);
                end
            end
        end else if (rst_n) begin
            tests++;
            if (bus_if.rsp_valid !== 1'b0 || bus_if.rsp_rdata !== 32'h0 || bus_if.rsp_fault !== 1'b0) begin
                fails++;
                $display("FAIL idle_outputs: got valid=%b rdata=%h fault=%b, required 0/0/0",
                         bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_fault);
            end
        end
    end

    task automatic send(input vec_t v);
        int n;
        repeat (v.gap) begin
            @(negedge clk);
            bus_if.req_valid = 1'b0;
        end
        @(negedge clk);
        bus_if.req_valid    = 1'b1;
        bus_if.req_write    = v.wr;
        bus_if.req_size     = v.size;
        bus_if.req_unsigned = v.uns;
        bus_if.req_addr     = v.addr;
        bus_if.req_wdata    = v.wdata;
        n = 0;
        while (bus_if.req_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bus_if.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL req%0d_accept: got req_ready=%b after %0d cycles, required 1", next_id, bus_if.req_ready, n);
            bus_if.req_valid = 1'b0;
        end else begin
            sbq.push_back('{id: next_id, rdata: v.exp_rdata, fault: v.exp_fault, due: cyc + LAT});
        end
        next_id++;
    endtask

    task automatic idle();
        @(negedge clk);
        bus_if.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d responses outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Number of falling edges after release until req_ready is seen high.
    task automatic check_ready_rise(input string name);
        int n;
        int exp_n;
`ifdef MEM_ZERO_INIT_EN
        exp_n = DEPTH + 1;
`else
        exp_n = 1;
`endif
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_if.req_ready !== 1'b1 && n < DEPTH + 20);
        tests++;
        if (n != exp_n) begin
            fails++;
            $display("FAIL %s: got req_ready after %0d cycles, required %0d", name, n, exp_n);
        end
    endtask

    task automatic check_in_reset(input string name);
        tests++;
        if (bus_if.req_ready !== 1'b0 || bus_if.rsp_valid !== 1'b0 ||
            bus_if.rsp_rdata !== 32'h0 || bus_if.rsp_fault !== 1'b0) begin
            fails++;
            $display("FAIL %s: got ready=%b valid=%b rdata=%h fault=%b, required all 0",
                     name, bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_fault);
        end
    endtask

    initial begin
        bus_if.req_valid    = 1'b0;
        bus_if.req_write    = 1'b0;
        bus_if.req_size     = SZ_WORD;
        bus_if.req_unsigned = 1'b0;
        bus_if.req_addr     = 32'h0;
        bus_if.req_wdata    = 32'h0;

        // gap, wr, size, uns, addr, wdata, expected rdata, expected fault
        vecs.push_back(mk(0, 1, SZ_WORD, 0, 32'h10,        32'h8000_00FF, 32'h0,         0));
        vecs.push_back(mk(0, 0, SZ_WORD, 0, 32'h10,        32'h0,         32'h8000_00FF, 0));
        vecs.push_back(mk(0, 0, SZ_BYTE, 0, 32'h10,        32'h0,         32'hFFFF_FF80, 0));
        vecs.push_back(mk(0, 0, SZ_BYTE, 1, 32'h10,        32'h0,         32'h0000_0080, 0));
        vecs.push_back(mk(0, 0, SZ_HALF, 0, 32'h12,        32'h0,         32'h0000_00FF, 0));
        vecs.push_back(mk(0, 0, SZ_HALF, 1, 32'h10,        32'h0,         32'h0000_8000, 0));
        vecs.push_back(mk(0, 0, SZ_HALF, 0, 32'h10,        32'h0,         32'hFFFF_8000, 0));
        vecs.push_back(mk(0, 0, SZ_BYTE, 0, 32'h13,        32'h0,         32'hFFFF_FFFF, 0));
        vecs.push_back(mk(2, 0, SZ_BYTE, 1, 32'h11,        32'h0,         32'h0,         0));
        vecs.push_back(mk(0, 1, SZ_WORD, 0, 32'h10,        32'h1122_3344, 32'h0,         0));
        vecs.push_back(mk(0, 1, SZ_BYTE, 0, 32'h11,        32'hFFFF_FFAB, 32'h0,         0));
        vecs.push_back(mk(0, 0, SZ_WORD, 0, 32'h10,        32'h0,         32'h11AB_3344, 0));
        vecs.push_back(mk(0, 0, SZ_HALF, 0, 32'h13,        32'h0,         32'h0,         1));
        vecs.push_back(mk(0, 1, SZ_WORD, 0, 32'h12,        32'hDEAD_BEEF, 32'h0,         1));
        vecs.push_back(mk(0, 0, 2'b11,   0, 32'h10,        32'h0,         32'h0,         1));
        vecs.push_back(mk(0, 1, 2'b11,   0, 32'h10,        32'hFFFF_FFFF, 32'h0,         1));
        vecs.push_back(mk(0, 1, SZ_HALF, 0, 32'h11,        32'h0000_7777, 32'h0,         1));
        vecs.push_back(mk(0, 0, SZ_WORD, 0, 32'h10,        32'h0,         32'h11AB_3344, 0));
        vecs.push_back(mk(1, 1, SZ_WORD, 0, 32'h20,        32'h0000_0005, 32'h0,         0));
        vecs.push_back(mk(0, 0, SZ_WORD, 0, 32'h20,        32'h0,         32'h0000_0005, 0));
        vecs.push_back(mk(0, 0, SZ_WORD, 0, 32'h1010,      32'h0,         32'h11AB_3344, 0));
        vecs.push_back(mk(0, 1, SZ_HALF, 0, 32'h1022,      32'hFFFF_CAFE, 32'h0,         0));
        vecs.push_back(mk(0, 0, SZ_WORD, 0, 32'h20,        32'h0,         32'h0000_CAFE, 0));
        vecs.push_back(mk(0, 0, SZ_HALF, 0, 32'h22,        32'h0,         32'hFFFF_CAFE, 0));
        vecs.push_back(mk(0, 1, SZ_HALF, 0, 32'h8000_0020, 32'h0000_1234, 32'h0,         0));
        vecs.push_back(mk(0, 0, SZ_WORD, 0, 32'h20,        32'h0,         32'h1234_CAFE, 0));
        vecs.push_back(mk(0, 1, SZ_BYTE, 0, 32'h23,        32'h0000_0099, 32'h0,         0));
        vecs.push_back(mk(0, 0, SZ_WORD, 0, 32'h20,        32'h0,         32'h1234_CA99, 0));
        vecs.push_back(mk(0, 0, SZ_BYTE, 1, 32'h22,        32'h0,         32'h0000_00CA, 0));

        // Power-on reset
        repeat (2) @(negedge clk);
        check_in_reset("por_outputs");
        rst_n = 1'b1;
        check_ready_rise("por_ready_rise");

        for (int i = 0; i < vecs.size(); i++) send(vecs[i]);
        idle();
        drain();

        // Reset with two loads in flight: responses must be discarded.
        send(mk(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'h11AB_3344, 0));
        send(mk(0, 0, SZ_WORD, 0, 32'h20, 32'h0, 32'h1234_CA99, 0));
        idle();
        #2;
        rst_n = 1'b0;
        sbq.delete();
        @(negedge clk);
        check_in_reset("midop_reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_ready_rise("midop_ready_rise");
        repeat (LAT + 2) @(negedge clk);

`ifdef MEM_ZERO_INIT_EN
        send(mk(0, 0, SZ_WORD, 0, 32'h10,  32'h0, 32'h0, 0));
        send(mk(0, 0, SZ_WORD, 0, 32'hFFC, 32'h0, 32'h0, 0));
        send(mk(0, 0, SZ_WORD, 0, 32'h20,  32'h0, 32'h0, 0));
`else
        send(mk(0, 0, SZ_WORD, 0, 32'h10,  32'h0, 32'h11AB_3344, 0));
        send(mk(0, 0, SZ_WORD, 0, 32'h20,  32'h0, 32'h1234_CA99, 0));
`endif
        idle();
        drain();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running at cyc %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_data_memory_sync.md
Name: mem_data_memory_sync

Overview:
- Synchronous, parametrised data memory for the MEM stage.
- Replaces the combinational data memory.
- Byte-addressed, big-endian, 32-bit words.
- Supports LB/LBU/LH/LHU/LW and SB/SH/SW with sign/zero extension and a fixed, parametrised response latency.
- Valid/ready request port and a response valid, so the pipeline can tolerate multi-cycle memory; misaligned or illegal accesses are flagged rather than silently corrupting memory.

Parameters:
- ADDR_WIDTH, 12: byte-address bits actually decoded; depth = 2**(ADDR_WIDTH-2) words.
- LATENCY, 1: cycles from request acceptance to rsp_valid; legal range 1..4.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address; bits above ADDR_WIDTH-1 ignored (wrap)
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response for the request accepted LATENCY cycles earlier
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  access was misaligned or had an illegal size

Behaviour:
- Accept when req_valid && req_ready at a rising edge; at most one request per cycle, fully pipelined.
- Reset: req_ready=0 while rst_n low, rsp_valid=0, rsp_rdata=0, rsp_fault=0, all in-flight pipeline stages cleared.
- FSM states:
  - INIT: only entered with MEM_ZERO_INIT_EN; req_ready=0.
  - RUN: req_ready=1.
  - Leaving reset goes to RUN on the first edge, or to INIT if the feature is compiled in.
- Big-endian byte lanes:
  - address offset 0 -> word bits [31:24], offset 3 -> [7:0];
  - halfword offset 0 -> [31:16], offset 2 -> [15:0].
- Fault rules:
  - halfword with addr[0]=1 -> fault;
  - word with addr[1:0]!=0 -> fault;
  - size 11 -> fault;
  - a faulted store writes nothing; a faulted load returns 0.
- Store: byte-enabled write of the addressed lanes at the acceptance edge; other lanes unchanged. The response (rsp_valid=1, rdata=0) follows LATENCY cycles later.
- Load:
  - array read at the acceptance edge;
  - the word passes through LATENCY-1 further register stages;
  - lane select and extension happen in the final stage;
  - rsp_rdata is valid with rsp_valid exactly LATENCY cycles after acceptance.
- Ordering and hazards:
  - Write then read, back-to-back to the same word: a store accepted in cycle N is visible to a load accepted in cycle N+1 or later.
  - Write then read, same cycle: impossible, since only one request is accepted per cycle.
- Response outputs:
  - Responses return strictly in order and the response path has no backpressure.
  - rsp_rdata and rsp_fault are 0 whenever rsp_valid=0.
- Wrap-around: address bits above ADDR_WIDTH-1 are ignored, so an address of 2**ADDR_WIDTH + k aliases k.
- Reset asserted mid-operation: pending responses are discarded and no partial write occurs beyond those already committed on earlier edges.

Optional Feature:
- Macro: MEM_ZERO_INIT_EN.
- Defined:
  - After reset release the FSM sits in INIT with a word counter from 0 to depth-1, writing 0 to one word per cycle; req_ready=0 throughout.
  - After the last word it moves to RUN, so req_ready rises exactly depth cycles after the first edge following reset release.
  - Reset during INIT restarts the sweep.
- Not defined: no INIT state; contents are undefined after power-up; req_ready=1 on the first edge after reset release.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - LATENCY_MAX=4;
  - FSM state enum (ST_INIT, ST_RUN);
  - a function for big-endian lane extract plus extend.
- One natural sub-module, mem_load_align: combinational lane select and sign/zero extension of a 32-bit word given offset, size and unsigned. It is instantiated in the final pipeline stage and reusable by the fetch path.

Test Plan:
- SW 0x8000_00FF to 0x10, then LW 0x10 -> rsp_rdata=0x8000_00FF, fault=0, exactly LATENCY cycles after the load.
- Same word: LB 0x10 -> 0xFFFF_FF80; LBU 0x10 -> 0x0000_0080; LH 0x12 -> 0x0000_00FF; LHU 0x10 -> 0x0000_8000.
- SB 0xAB to 0x11 over word 0x1122_3344 at 0x10, then LW 0x10 -> 0x11AB_3344.
- LH 0x13, SW to 0x12 and size 11 -> all three report fault=1 with rdata=0; a later LW shows memory unchanged.
- Back-to-back SW 0x5 to 0x20 then LW 0x20 in the next cycle, with LATENCY=3 -> response 0x5 at +3.
- Reset mid-operation: assert rst_n=0 with two loads in flight -> no rsp_valid after release. With MEM_ZERO_INIT_EN, req_ready stays 0 for depth cycles and LW of any address then returns 0.
